ball_ctl: RTL and testbench

Frame-rate game sequencer for the pong datapath. It owns the ball position (`x_ball`, `y_ball`) consumed by the ball/pad renderer, advances it once per video frame, bounces it off the walls and pads, detects misses, keeps score and runs the serve / play / game-over sequence. It sits between the frame-tick source (start of vertical blank) and the drawing stage, alongside the pad controllers that supply `y_pad_left` and `y_pad_right`.

---
 rtl/ball_ctl_if.sv | 24 ++
 rtl/ball_ctl.sv | 212 +++++++++++++++++++++
 tb/tb_ball_ctl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/ball_ctl_if.sv
// Signal bundle between the pong sequencer, its frame/pad sources and the renderer.
interface ball_ctl_if;
   logic        frame_tick;
   logic        start;
   logic [9:0]  y_pad_left;
   logic [9:0]  y_pad_right;
   logic [10:0] x_ball;
   logic [9:0]  y_ball;
   logic [3:0]  score_left;
   logic [3:0]  score_right;
   logic        point_left;
   logic        point_right;
   logic        game_over;

   modport master (
      output frame_tick, start, y_pad_left, y_pad_right,
      input  x_ball, y_ball, score_left, score_right, point_left, point_right, game_over
   );

   modport slave (
      input  frame_tick, start, y_pad_left, y_pad_right,
      output x_ball, y_ball, score_left, score_right, point_left, point_right, game_over
   );
endinterface

// File: rtl/ball_ctl.sv
// Pong game sequencer: advances the ball once per frame tick, bounces it off walls and pads,
// detects misses, keeps score and runs the serve / play / game-over sequence.
module ball_ctl #(
   parameter int unsigned H_FIELD      = 1024,
   parameter int unsigned V_FIELD      = 768,
   parameter int unsigned BALL_SIZE    = 15,
   parameter int unsigned PAD_HEIGHT   = 145,
   parameter int unsigned PAD_WIDTH    = 15,
   parameter int unsigned X_PAD_LEFT   = 30,
   parameter int unsigned X_PAD_RIGHT  = 979,
   parameter int unsigned SPEED        = 4,
   parameter int unsigned SERVE_FRAMES = 60,
   parameter int unsigned WIN_SCORE    = 9
) (
   input  logic      clk,
   input  logic      rst,
   ball_ctl_if.slave bus
);

   localparam logic [11:0] XC  = 12'((H_FIELD - BALL_SIZE) / 2);
   localparam logic [11:0] YC  = 12'((V_FIELD - BALL_SIZE) / 2);
   localparam logic [11:0] LF  = 12'(X_PAD_LEFT + PAD_WIDTH);
   localparam logic [11:0] XR  = 12'(X_PAD_RIGHT);
   localparam logic [11:0] SP  = 12'(SPEED);
   localparam logic [11:0] BS  = 12'(BALL_SIZE);
   localparam logic [11:0] PH  = 12'(PAD_HEIGHT);
   localparam logic [11:0] HM  = 12'(H_FIELD - 1);
   localparam logic [11:0] VM  = 12'(V_FIELD - 1);
   localparam logic [3:0]  WIN = 4'(WIN_SCORE);
   localparam int unsigned CntW = $clog2(SERVE_FRAMES + 2);
   localparam logic [CntW-1:0] ServeN = CntW'(SERVE_FRAMES);

   typedef enum logic [2:0] {StIdle, StServe, StPlay, StScored, StGameOver} state_e;

   state_e          state_q, state_d;
   logic [10:0]     x_q, x_d;
   logic [9:0]      y_q, y_d;
   logic            dir_x_q, dir_x_d;  // 1 = right
   logic            dir_y_q, dir_y_d;  // 1 = down
   logic [3:0]      score_l_q, score_l_d, score_r_q, score_r_d;
   logic            point_l_q, point_l_d, point_r_q, point_r_d;
   logic            game_over_q, game_over_d;
   logic            scorer_r_q, scorer_r_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   logic [11:0] x12, y12, pl12, pr12, x_nxt, y_nxt;
   logic        ovl_l, ovl_r, dir_x_nxt, dir_y_nxt, miss, right_scores;

   assign x12   = {1'b0, x_q};
   assign y12   = {2'b00, y_q};
   assign pl12  = {2'b00, bus.y_pad_left};
   assign pr12  = {2'b00, bus.y_pad_right};
   assign ovl_l = (y12 + BS >= pl12) && (y12 <= pl12 + PH);
   assign ovl_r = (y12 + BS >= pr12) && (y12 <= pr12 + PH);

   // Candidate move for one frame; applied only by PLAY on a tick without a miss.
   always_comb begin
      y_nxt        = y12;
      dir_y_nxt    = dir_y_q;
      x_nxt        = x12;
      dir_x_nxt    = dir_x_q;
      miss         = 1'b0;
      right_scores = 1'b0;
      if (!dir_y_q) begin
         if (y12 <= SP) begin
            y_nxt     = '0;
            dir_y_nxt = 1'b1;
         end else begin
            y_nxt = y12 - SP;
         end
      end else if (y12 + BS + SP >= VM) begin
         y_nxt     = VM - BS;
         dir_y_nxt = 1'b0;
      end else begin
         y_nxt = y12 + SP;
      end
      if (!dir_x_q) begin
         if (x12 > LF && x12 <= LF + SP && ovl_l) begin
            x_nxt     = LF + 12'd1;
            dir_x_nxt = 1'b1;
         end else if (x12 <= SP) begin
            miss         = 1'b1;
            right_scores = 1'b1;
         end else begin
            x_nxt = x12 - SP;
         end
      end else begin
         if (x12 + BS < XR && x12 + BS + SP >= XR && ovl_r) begin
            x_nxt     = XR - 12'd1 - BS;
            dir_x_nxt = 1'b0;
         end else if (x12 + BS + SP >= HM) begin
            miss = 1'b1;
         end else begin
            x_nxt = x12 + SP;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      dir_x_d    = dir_x_q;
      dir_y_d    = dir_y_q;
      score_l_d  = score_l_q;
      score_r_d  = score_r_q;
      point_l_d  = 1'b0;
      point_r_d  = 1'b0;
      scorer_r_d = scorer_r_q;
      cnt_d      = cnt_q;
      unique case (state_q)
         StIdle: begin
            x_d = XC[10:0];
            y_d = YC[9:0];
            if (bus.start) begin
               score_l_d = '0;
               score_r_d = '0;
               cnt_d     = '0;
               state_d   = StServe;
            end
         end
         StServe: begin
            x_d = XC[10:0];
            y_d = YC[9:0];
            if (cnt_q == ServeN) begin
               cnt_d   = '0;
               state_d = StPlay;
            end else if (bus.frame_tick) begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StPlay: begin
            if (bus.frame_tick) begin
               if (miss) begin
                  // Score and pulse land together so both are visible during StScored.
                  scorer_r_d = right_scores;
                  state_d    = StScored;
                  if (right_scores) begin
                     point_r_d = 1'b1;
                     score_r_d = (score_r_q == WIN) ? score_r_q : score_r_q + 4'd1;
                  end else begin
                     point_l_d = 1'b1;
                     score_l_d = (score_l_q == WIN) ? score_l_q : score_l_q + 4'd1;
                  end
               end else begin
                  x_d     = x_nxt[10:0];
                  y_d     = y_nxt[9:0];
                  dir_x_d = dir_x_nxt;
                  dir_y_d = dir_y_nxt;
               end
            end
         end
         StScored: begin
            x_d     = XC[10:0];
            y_d     = YC[9:0];
            dir_x_d = ~scorer_r_q;
            state_d = (((scorer_r_q) ? score_r_q : score_l_q) == WIN) ? StGameOver : StServe;
         end
         StGameOver: begin
            x_d = XC[10:0];
            y_d = YC[9:0];
            if (bus.start) begin
               score_l_d = '0;
               score_r_d = '0;
               cnt_d     = '0;
               state_d   = StServe;
            end
         end
         default: state_d = StIdle;
      endcase
      game_over_d = (state_d == StGameOver);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         x_q         <= XC[10:0];
         y_q         <= YC[9:0];
         dir_x_q     <= 1'b1;
         dir_y_q     <= 1'b1;
         score_l_q   <= '0;
         score_r_q   <= '0;
         point_l_q   <= 1'b0;
         point_r_q   <= 1'b0;
         game_over_q <= 1'b0;
         scorer_r_q  <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         dir_x_q     <= dir_x_d;
         dir_y_q     <= dir_y_d;
         score_l_q   <= score_l_d;
         score_r_q   <= score_r_d;
         point_l_q   <= point_l_d;
         point_r_q   <= point_r_d;
         game_over_q <= game_over_d;
         scorer_r_q  <= scorer_r_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus.x_ball      = x_q;
   assign bus.y_ball      = y_q;
   assign bus.score_left  = score_l_q;
   assign bus.score_right = score_r_q;
   assign bus.point_left  = point_l_q;
   assign bus.point_right = point_r_q;
   assign bus.game_over   = game_over_q;

endmodule

// File: tb/tb_ball_ctl.sv
// Bench for ball_ctl: directed game scenario with literal pins, then random play, all
// cross-checked every cycle against a frame-level behavioural model of the game rules.
module tb_ball_ctl;
   localparam int SF  = 3;
   localparam int WIN = 2;
   localparam int XC = 504, YC = 376, LF = 45, XPR = 979, BS = 15, PH = 145, SP = 4;
   localparam int HF = 1024, VF = 768;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   bit   cmp_en = 1'b0;

   ball_ctl_if bus ();

   ball_ctl #(
      .SERVE_FRAMES(SF),
      .WIN_SCORE   (WIN)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Game model: phase names follow the game rules, positions as plain integers.
   typedef enum int {MIdle, MServe, MPlay, MScored, MOver} phase_t;
   phase_t m_ph;
   int m_x, m_y, m_dx, m_dy, m_sl, m_sr, m_cnt;
   bit m_pl, m_pr, m_go, m_right_scored;

   function automatic bit overlaps(input int y, input int pad);
      return (y + BS >= pad) && (y <= pad + PH);
   endfunction

   task automatic model_reset();
      m_ph = MIdle; m_x = XC; m_y = YC; m_dx = 1; m_dy = 1;
      m_sl = 0; m_sr = 0; m_cnt = 0; m_pl = 0; m_pr = 0; m_go = 0; m_right_scored = 0;
   endtask

   task automatic model_step();
      int nx, ny, ndx, ndy;
      bit lost, r_scores;
      m_pl = 0;
      m_pr = 0;
      case (m_ph)
         MIdle, MOver: if (bus.start) begin
            m_sl = 0; m_sr = 0; m_cnt = 0; m_ph = MServe;
         end
         MServe: begin
            if (m_cnt == SF) begin
               m_cnt = 0; m_ph = MPlay;
            end else if (bus.frame_tick) m_cnt++;
         end
         MPlay: if (bus.frame_tick) begin
            ny = m_y + m_dy * SP; ndy = m_dy;
            if (m_dy < 0 && m_y <= SP) begin ny = 0; ndy = 1; end
            if (m_dy > 0 && m_y + BS + SP >= VF - 1) begin ny = VF - 1 - BS; ndy = -1; end
            nx = m_x + m_dx * SP; ndx = m_dx; lost = 0; r_scores = 0;
            if (m_dx < 0) begin
               if (m_x > LF && m_x - SP <= LF && overlaps(m_y, int'(bus.y_pad_left))) begin
                  nx = LF + 1; ndx = 1;
               end else if (m_x <= SP) begin
                  lost = 1; r_scores = 1;
               end
            end else begin
               if (m_x + BS < XPR && m_x + BS + SP >= XPR &&
                   overlaps(m_y, int'(bus.y_pad_right))) begin
                  nx = XPR - 1 - BS; ndx = -1;
               end else if (m_x + BS + SP >= HF - 1) begin
                  lost = 1;
               end
            end
            if (lost) begin
               m_right_scored = r_scores;
               if (r_scores) begin m_sr = (m_sr < WIN) ? m_sr + 1 : m_sr; m_pr = 1; end
               else begin m_sl = (m_sl < WIN) ? m_sl + 1 : m_sl; m_pl = 1; end
               m_ph = MScored;
            end else begin
               m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy;
            end
         end
         MScored: begin
            m_x = XC; m_y = YC;
            m_dx = m_right_scored ? -1 : 1;
            m_ph = ((m_right_scored ? m_sr : m_sl) == WIN) ? MOver : MServe;
         end
         default: m_ph = MIdle;
      endcase
      m_go = (m_ph == MOver);
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) model_reset();
      else model_step();
   end

   always @(negedge clk) begin
      if (cmp_en && !rst) begin
         chk("x_ball", 32'(bus.x_ball), m_x);
         chk("y_ball", 32'(bus.y_ball), m_y);
         chk("score_left", 32'(bus.score_left), m_sl);
         chk("score_right", 32'(bus.score_right), m_sr);
         chk("point_left", 32'(bus.point_left), 32'(m_pl));
         chk("point_right", 32'(bus.point_right), 32'(m_pr));
         chk("game_over", 32'(bus.game_over), 32'(m_go));
      end
   end

   task automatic cyc(input bit tick, input bit st);
      bus.frame_tick = tick;
      bus.start      = st;
      @(negedge clk);
   endtask

   task automatic frame();
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
   endtask

   task automatic play_until_right_point(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         cyc(1'b1, 1'b0);
         if (bus.point_right === 1'b1) seen = 1'b1;
         else cyc(1'b0, 1'b0);
      end
   endtask

   initial begin
      bit seen;
      bus.frame_tick  = 1'b0;
      bus.start       = 1'b0;
      bus.y_pad_left  = 10'd900;
      bus.y_pad_right = 10'd600;
      #2 rst = 1'b1;
      #1;
      chk("reset_x", 32'(bus.x_ball), 504);
      chk("reset_y", 32'(bus.y_ball), 376);
      chk("reset_scores", {24'd0, bus.score_left, bus.score_right}, 0);
      chk("reset_game_over", 32'(bus.game_over), 0);
      @(negedge clk);
      rst    = 1'b0;
      cmp_en = 1'b1;

      // Serve delay: three held frames, movement on the fourth.
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b0);
      for (int i = 0; i < SF; i++) frame();
      chk("serve_hold_x", 32'(bus.x_ball), 504);
      chk("serve_hold_y", 32'(bus.y_ball), 376);
      frame();
      chk("first_move_x", 32'(bus.x_ball), 508);
      chk("first_move_y", 32'(bus.y_ball), 380);

      // Bottom wall: 748 -> clamp 752 -> 748.
      for (int i = 1; i < 93; i++) frame();
      chk("pre_wall_y", 32'(bus.y_ball), 748);
      chk("pre_wall_x", 32'(bus.x_ball), 876);
      frame();
      chk("wall_clamp_y", 32'(bus.y_ball), 752);
      frame();
      chk("wall_back_y", 32'(bus.y_ball), 748);

      // Right pad at 600 catches the ball at x=960.
      for (int i = 95; i < 114; i++) frame();
      chk("pre_pad_x", 32'(bus.x_ball), 960);
      frame();
      chk("pad_hit_x", 32'(bus.x_ball), 963);
      frame();
      chk("pad_return_x", 32'(bus.x_ball), 959);

      // Left pad far away: ball is missed, right player scores.
      play_until_right_point(seen);
      chk("miss1_seen", 32'(seen), 1);
      chk("miss1_score_right", 32'(bus.score_right), 1);
      cyc(1'b0, 1'b0);
      chk("recentre_x", 32'(bus.x_ball), 504);
      cyc(1'b0, 1'b0);
      for (int i = 0; i < SF; i++) frame();
      frame();
      chk("serve_toward_left", 32'(bus.x_ball), 500);

      play_until_right_point(seen);
      chk("miss2_seen", 32'(seen), 1);
      chk("miss2_score_right", 32'(bus.score_right), 2);
      cyc(1'b0, 1'b0);
      chk("game_over_set", 32'(bus.game_over), 1);
      frame();
      chk("over_frozen_x", 32'(bus.x_ball), 504);
      chk("over_frozen_y", 32'(bus.y_ball), 376);
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b0);
      chk("restart_score", 32'(bus.score_right), 0);
      chk("restart_game_over", 32'(bus.game_over), 0);

      // Asynchronous reset mid-play, checked before any clock edge.
      for (int i = 0; i < SF + 6; i++) frame();
      #2 rst = 1'b1;
      #1;
      chk("midplay_reset_x", 32'(bus.x_ball), 504);
      chk("midplay_reset_y", 32'(bus.y_ball), 376);
      chk("midplay_reset_go", 32'(bus.game_over), 0);
      @(negedge clk);
      rst = 1'b0;

      // Random play.
      for (int c = 0; c < 4000; c++) begin
         if (c % 40 == 0) begin
            bus.y_pad_left  = 10'($urandom_range(0, 640));
            bus.y_pad_right = 10'($urandom_range(0, 640));
         end
         cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 60) == 0));
      end

      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
